// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MEM-stage data-memory access unit for the 64-bit RISC-V
//            pipeline. Turns the load/store fields of the EXE/MEM register
//            into one request per instruction on a req/ready + rvalid data
//            port. Store data is shifted into its byte lanes. Load data is
//            extracted from the returned doubleword and sign- or
//            zero-extended. StallM freezes IF..MEM until the access completes.
//
// Ports    : clk, reset      - clock, asynchronous active-high reset
//            MemReadM        - load in MEM
//            MemWriteM       - store in MEM (wins over MemReadM)
//            MemTypeM        - 00 byte, 01 half, 10 word, 11 double
//            MemUnsignedM    - zero-extend loads
//            ALUResultM      - effective byte address
//            WriteDataM      - right-justified store data
//            StallM          - hold IF..MEM pipeline registers
//            ReadDataM       - registered, extended load result
//            MisalignM       - misaligned access (no request is issued)
//            mem_req/mem_we/mem_addr/mem_wdata/mem_be - request side
//            mem_ready       - request accepted this cycle
//            mem_rdata/mem_rvalid - read-data return
//            BusErrM         - access timed out (optional feature only)
//
// Options  : `define MEM_ACCESS_TIMEOUT_EN adds a wait-cycle counter and the
//            BusErrM output. An access that waits TIMEOUT_CYCLES cycles in
//            REQ/WAIT_R is abandoned. Without the macro the FSM waits
//            indefinitely.
//
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [1:0]  MemTypeM,
  input  logic        MemUnsignedM,
  input  logic [63:0] ALUResultM,
  input  logic [63:0] WriteDataM,
  output logic        StallM,
  output logic [63:0] ReadDataM,
  output logic        MisalignM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_be,
  input  logic        mem_ready,
  input  logic [63:0] mem_rdata,
  input  logic        mem_rvalid
`ifdef MEM_ACCESS_TIMEOUT_EN
  ,
  output logic        BusErrM
`endif
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] WAIT_R = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_next;

  logic        access;
  logic [2:0]  off;
  logic        misaligned;
  logic [7:0]  be_base;
  logic [63:0] lane;
  logic [63:0] load_ext;
  logic        expire;      // wait budget exhausted this cycle
  logic        capture;     // load data returns this cycle
  logic        err_set;     // abandon the access this cycle

  // --------------------------------------------------------------------------
  // Request formatting
  // --------------------------------------------------------------------------
  assign access = MemReadM | MemWriteM;
  assign off    = ALUResultM[2:0];

  always_comb begin
    misaligned = 1'b0;
    be_base    = 8'hFF;
    case (MemTypeM)
      2'b00: begin
        misaligned = 1'b0;
        be_base    = 8'h01;
      end
      2'b01: begin
        misaligned = off[0];
        be_base    = 8'h03;
      end
      2'b10: begin
        misaligned = |off[1:0];
        be_base    = 8'h0F;
      end
      default: begin
        misaligned = |off;
        be_base    = 8'hFF;
      end
    endcase
  end

  // Request fields are driven straight from the EXE/MEM register. While
  // StallM is high that register is frozen, so the fields stay stable
  // through REQ without a local copy.
  assign mem_addr  = {ALUResultM[63:3], 3'b000};
  assign mem_we    = MemWriteM;
  assign mem_be    = be_base << off;
  assign mem_wdata = WriteDataM << {off, 3'b000};

  // --------------------------------------------------------------------------
  // Load extraction and extension. A double uses the whole lane, so
  // MemUnsignedM has no effect on it.
  // --------------------------------------------------------------------------
  assign lane = mem_rdata >> {off, 3'b000};

  always_comb begin
    load_ext = lane;
    case (MemTypeM)
      2'b00:   load_ext = MemUnsignedM ? {56'd0, lane[7:0]}
                                       : {{56{lane[7]}}, lane[7:0]};
      2'b01:   load_ext = MemUnsignedM ? {48'd0, lane[15:0]}
                                       : {{48{lane[15]}}, lane[15:0]};
      2'b10:   load_ext = MemUnsignedM ? {32'd0, lane[31:0]}
                                       : {{32{lane[31]}}, lane[31:0]};
      default: load_ext = lane;
    endcase
  end

  // --------------------------------------------------------------------------
  // Optional wait-cycle watchdog
  // --------------------------------------------------------------------------
`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

  logic [CNT_W-1:0] cnt;

  // The counter holds the number of cycles already spent in the wait state.
  // The access expires in the TIMEOUT_CYCLES-th wait cycle. mem_req is
  // already low in that cycle, so a late mem_ready cannot be taken as an
  // accept.
  assign expire = ((state == REQ) || (state == WAIT_R)) &&
                  (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state_next != state) begin
      cnt <= '0;
    end else if ((state == REQ) || (state == WAIT_R)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // err_set is only raised on the edge into DONE. Registering it therefore
  // gives exactly the one DONE cycle, and BusErrM clears again in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      BusErrM <= 1'b0;
    end else begin
      BusErrM <= err_set;
    end
  end
`else
  assign expire = 1'b0;

  logic unused_timeout_param;
  assign unused_timeout_param = ^TIMEOUT_CYCLES;
`endif

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    mem_req    = 1'b0;
    StallM     = 1'b0;
    MisalignM  = 1'b0;
    capture    = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        if (access) begin
          if (misaligned) begin
            // No request. The pipeline advances and traps downstream.
            MisalignM = 1'b1;
          end else begin
            mem_req = 1'b1;
            StallM  = 1'b1;
            if (mem_ready) begin
              state_next = MemWriteM ? DONE : WAIT_R;
            end else begin
              state_next = REQ;
            end
          end
        end
      end
      REQ: begin
        StallM = 1'b1;
        if (expire) begin
          err_set    = 1'b1;
          state_next = DONE;
        end else begin
          mem_req = 1'b1;
          if (mem_ready) begin
            state_next = MemWriteM ? DONE : WAIT_R;
          end
        end
      end
      WAIT_R: begin
        StallM = 1'b1;
        // Data that arrives in the expiry cycle is still valid data, so it
        // takes priority over the timeout.
        if (mem_rvalid) begin
          capture    = 1'b1;
          state_next = DONE;
        end else if (expire) begin
          err_set    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        // The pipeline advances on this edge. Returning to IDLE guarantees
        // one request per instruction.
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Reset forces the state to IDLE asynchronously. The pipeline inputs may
    // still show an access, so the handshake and stall outputs are also
    // gated directly for the whole reset window.
    if (reset) begin
      mem_req   = 1'b0;
      StallM    = 1'b0;
      MisalignM = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ReadDataM <= 64'd0;
    end else begin
      state <= state_next;
      if (capture) begin
        ReadDataM <= load_ext;
      end else if (err_set) begin
        ReadDataM <= 64'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit. A byte-loop reference
//            model produces the expected request fields and load results.
//            These are queued when an access is driven and popped when the
//            DUT accepts the write or completes the load.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        MemReadM;
  logic        MemWriteM;
  logic [1:0]  MemTypeM;
  logic        MemUnsignedM;
  logic [63:0] ALUResultM;
  logic [63:0] WriteDataM;
  logic        StallM;
  logic [63:0] ReadDataM;
  logic        MisalignM;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_be;
  logic        mem_ready;
  logic [63:0] mem_rdata;
  logic        mem_rvalid;
`ifdef MEM_ACCESS_TIMEOUT_EN
  logic        BusErrM;
`endif

  mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .reset        (reset),
    .MemReadM     (MemReadM),
    .MemWriteM    (MemWriteM),
    .MemTypeM     (MemTypeM),
    .MemUnsignedM (MemUnsignedM),
    .ALUResultM   (ALUResultM),
    .WriteDataM   (WriteDataM),
    .StallM       (StallM),
    .ReadDataM    (ReadDataM),
    .MisalignM    (MisalignM),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid)
`ifdef MEM_ACCESS_TIMEOUT_EN
    ,
    .BusErrM      (BusErrM)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counters and scoreboard
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  be;
  } wr_t;

  wr_t         wr_q[$];
  logic [63:0] rd_q[$];
  logic [63:0] last_load = 64'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model, written byte by byte
  // --------------------------------------------------------------------------
  function automatic bit model_mis(input logic [1:0] typ, input logic [2:0] off);
    int sz = 1 << typ;
    return (int'(off) % sz) != 0;
  endfunction

  function automatic logic [7:0] model_be(input logic [1:0] typ, input logic [2:0] off);
    logic [7:0] b = 8'd0;
    for (int i = 0; i < (1 << typ); i++)
      if (int'(off) + i < 8) b[int'(off) + i] = 1'b1;
    return b;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] wd, input logic [2:0] off);
    logic [63:0] w = 64'd0;
    for (int i = 0; i < 8; i++)
      if (i >= int'(off)) w[8*i +: 8] = wd[8*(i - int'(off)) +: 8];
    return w;
  endfunction

  function automatic logic [63:0] model_load(input logic [1:0] typ, input logic uns,
                                             input logic [2:0] off, input logic [63:0] rd);
    logic [63:0] v = 64'd0;
    int n = 1 << typ;
    for (int i = 0; i < n; i++)
      if (int'(off) + i < 8) v[8*i +: 8] = rd[8*(int'(off) + i) +: 8];
    if (!uns && v[8*n - 1])
      for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // One access: drive it, play the memory, score the result
  // --------------------------------------------------------------------------
  task automatic run_access(input string name, input logic rd, input logic wr,
                            input logic [1:0] typ, input logic uns,
                            input logic [63:0] addr, input logic [63:0] wd,
                            input logic [63:0] rdata, input int rdy_dly, input int rv_dly);
    logic [2:0] off  = addr[2:0];
    bit         mis  = model_mis(typ, off);
    bit         w    = wr;
    bit         load = rd && !wr;
    int         exp_stall;
    int         stall = 0;
    int         acc_c = -1;
    bit         done  = 0;
    wr_t        e;

    if (!mis) begin
      if (w) begin
        e.addr  = {addr[63:3], 3'b000};
        e.wdata = model_wdata(wd, off);
        e.be    = model_be(typ, off);
        wr_q.push_back(e);
      end
      if (load) begin
        rd_q.push_back(model_load(typ, uns, off, rdata));
        last_load = model_load(typ, uns, off, rdata);
      end
    end
    exp_stall = mis ? 0 : (w ? rdy_dly + 1 : rdy_dly + 2 + rv_dly);

    @(negedge clk);
    MemReadM     = rd;
    MemWriteM    = wr;
    MemTypeM     = typ;
    MemUnsignedM = uns;
    ALUResultM   = addr;
    WriteDataM   = wd;
    mem_ready    = (rdy_dly == 0);
    mem_rvalid   = 1'b0;
    mem_rdata    = 64'hDEAD_BEEF_0BAD_F00D;

    for (int k = 0; k < 100; k++) begin
      #1;
      if (!StallM) begin
        done = 1;
        break;
      end
      stall++;
      check({name, " req"}, mem_req, acc_c < 0);
      if (w && mem_req && wr_q.size() > 0) begin
        check({name, " addr"}, mem_addr, wr_q[0].addr);
        check({name, " wdata"}, mem_wdata, wr_q[0].wdata);
        check({name, " be"}, mem_be, wr_q[0].be);
      end
      if (mem_req && mem_ready) begin
        acc_c = k;
        check({name, " we"}, mem_we, w);
        if (!w) check({name, " raddr"}, mem_addr, {addr[63:3], 3'b000});
        if (w && wr_q.size() > 0) void'(wr_q.pop_front());
      end
      @(negedge clk);
      mem_ready  = (acc_c < 0) && (k + 1 >= rdy_dly);
      mem_rvalid = load && (acc_c >= 0) && (k + 1 >= acc_c + 1 + rv_dly);
      if (mem_rvalid) mem_rdata = rdata;
    end

    check({name, " completes"}, done, 1'b1);
    check({name, " stall"}, stall, exp_stall);
    check({name, " misalign"}, MisalignM, mis);
    check({name, " req_end"}, mem_req, 1'b0);
    if (load && !mis && done && rd_q.size() > 0)
      check({name, " rdata"}, ReadDataM, rd_q.pop_front());

    // Pipeline advances: the next instruction is not an access.
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_req;
    int n_stall;
    bit fin;

    reset        = 1'b1;
    MemReadM     = 1'b0;
    MemWriteM    = 1'b0;
    MemTypeM     = 2'b00;
    MemUnsignedM = 1'b0;
    ALUResultM   = 64'd0;
    WriteDataM   = 64'd0;
    mem_ready    = 1'b0;
    mem_rdata    = 64'd0;
    mem_rvalid   = 1'b0;

    // Reset state, including an access presented while reset is held
    @(negedge clk);
    @(negedge clk);
    MemReadM   = 1'b1;
    MemTypeM   = 2'b11;
    ALUResultM = 64'h1000;
    #1;
    check("rst req", mem_req, 1'b0);
    check("rst stall", StallM, 1'b0);
    check("rst misalign", MisalignM, 1'b0);
    check("rst rdata", ReadDataM, 64'd0);
`ifdef MEM_ACCESS_TIMEOUT_EN
    check("rst buserr", BusErrM, 1'b0);
`endif
    MemReadM = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle req", mem_req, 1'b0);
    check("idle stall", StallM, 1'b0);

    // Directed accesses
    run_access("sd", 0, 1, 2'b11, 0, 64'h1000, 64'h1122334455667788, 64'd0, 0, 0);
    run_access("sb", 0, 1, 2'b00, 0, 64'h2005, 64'h00000000000000AB, 64'd0, 3, 0);
    run_access("lh_s", 1, 0, 2'b01, 0, 64'h3002, 64'd0, 64'h0000000080010000, 0, 0);
    check("lh_s const", ReadDataM, 64'hFFFFFFFFFFFF8001);
    run_access("lh_u", 1, 0, 2'b01, 1, 64'h3002, 64'd0, 64'h0000000080010000, 0, 0);
    check("lh_u const", ReadDataM, 64'h0000000000008001);
    run_access("lw_mis", 1, 0, 2'b10, 0, 64'h4003, 64'd0, 64'd0, 0, 0);
    run_access("sh_mis", 0, 1, 2'b01, 0, 64'h4001, 64'h1234, 64'd0, 0, 0);
    check("hold after mis", ReadDataM, last_load);
    run_access("lb_s7", 1, 0, 2'b00, 0, 64'h5007, 64'd0, 64'h80FFFFFFFFFFFFFF, 1, 2);
    run_access("lw_u4", 1, 0, 2'b10, 1, 64'h5104, 64'd0, 64'hF234567800000000, 2, 1);
    run_access("ld", 1, 0, 2'b11, 1, 64'h5200, 64'd0, 64'h8877665544332211, 2, 0);
    run_access("sh6", 0, 1, 2'b01, 0, 64'h5306, 64'hFFFF_FFFF_FFFF_BEEF, 64'd0, 1, 0);
    run_access("sw4", 0, 1, 2'b10, 0, 64'h5404, 64'h0000_0000_CAFE_F00D, 64'd0, 0, 0);
    check("hold after st", ReadDataM, last_load);
    run_access("rw_both", 1, 1, 2'b11, 0, 64'h5500, 64'h0102030405060708, 64'h1111, 0, 0);
    check("hold after rw", ReadDataM, last_load);

    // Randomised aligned/misaligned mix
    for (int i = 0; i < 12; i++) begin
      logic [1:0]  typ = 2'($urandom_range(0, 3));
      logic [2:0]  off = 3'($urandom_range(0, 7));
      bit          wr  = bit'($urandom_range(0, 1));
      logic [63:0] a   = {32'($urandom), 29'($urandom), off};
      run_access("rnd", !wr, wr, typ, 1'($urandom_range(0, 1)), a,
                 {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
                 $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Make ReadDataM non-zero so the reset check below is meaningful
    run_access("ld_pre", 1, 0, 2'b11, 0, 64'h6000, 64'd0, 64'hA5A5_0000_1234_5678, 0, 0);

    // Reset while waiting for read data
    @(negedge clk);
    MemReadM   = 1'b1;
    MemTypeM   = 2'b11;
    ALUResultM = 64'h6100;
    mem_ready  = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check("wr stall", StallM, 1'b1);
    reset = 1'b1;
    #1;
    check("midrst req", mem_req, 1'b0);
    check("midrst stall", StallM, 1'b0);
    check("midrst rdata", ReadDataM, 64'd0);
    MemReadM = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    check("late rvalid rdata", ReadDataM, 64'd0);
    check("late rvalid stall", StallM, 1'b0);
    last_load = 64'd0;

`ifdef MEM_ACCESS_TIMEOUT_EN
    run_access("ld_pre2", 1, 0, 2'b11, 0, 64'h7000, 64'd0, 64'h0123_4567_89AB_CDEF, 0, 0);
    @(negedge clk);
    MemReadM   = 1'b1;
    MemTypeM   = 2'b11;
    ALUResultM = 64'h7100;
    mem_ready  = 1'b0;
    n_req   = 0;
    n_stall = 0;
    fin     = 0;
    for (int k = 0; k < 50; k++) begin
      #1;
      if (!StallM) begin
        fin = 1;
        break;
      end
      n_stall++;
      if (mem_req) n_req++;
      @(negedge clk);
    end
    check("to completes", fin, 1'b1);
    check("to req cycles", n_req, TO);
    check("to stall cycles", n_stall, TO + 1);
    check("to buserr", BusErrM, 1'b1);
    check("to rdata", ReadDataM, 64'd0);
    MemReadM = 1'b0;
    @(negedge clk);
    #1;
    check("to buserr clr", BusErrM, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
